// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF-stage fetch sequencer (fetch_ctrl, fetch_fifo).
package fetch_pkg;

   localparam int unsigned FETCH_WIDTH = 32;
   localparam logic [FETCH_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam int unsigned PC_INC = 4;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      SQUASH
   } fetch_state_t;

   typedef struct packed {
      logic [FETCH_WIDTH-1:0] pc;
      logic [FETCH_WIDTH-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc,instr} fetch entries with a single-cycle flush and an occupancy count.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter  int unsigned DEPTH = 2,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic          i_clock,
   input  logic          i_reset_n,
   input  logic          i_flush,
   input  logic          i_push,
   input  fetch_entry_t  i_data,
   input  logic          i_pop,
   output fetch_entry_t  o_data,
   output logic [CW-1:0] o_count
);

   fetch_entry_t  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign w_do_push = i_push && (r_count != CW'(DEPTH));
   assign w_do_pop  = i_pop && (r_count != '0);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
      end
   end

   // NOTE: storage is not reset; the head output is forced to zero whenever the FIFO is empty.
   always_ff @(posedge i_clock) begin
      if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_data  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
   assign o_count = r_count;

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage sequencer: PC, single-outstanding imem handshake, redirect squash, fetch buffer to ID.
// Define FETCH_PERF_CNT_EN to add saturating stall/flush counters (o_stall_cnt, o_flush_cnt).
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int unsigned      WIDTH      = FETCH_WIDTH,
   parameter logic [WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int unsigned      FIFO_DEPTH = 2
) (
   input  logic             i_clock,
   input  logic             i_reset_n,
   output logic             o_imem_req,
   output logic [WIDTH-1:0] o_imem_addr,
   input  logic             i_imem_gnt,
   input  logic             i_imem_rvalid,
   input  logic [WIDTH-1:0] i_imem_rdata,
   input  logic             i_redirect,
   input  logic [WIDTH-1:0] i_redirect_pc,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_instr,
   output logic [WIDTH-1:0] o_instr_pc,
   input  logic             i_id_ready
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]      o_stall_cnt,
   output logic [31:0]      o_flush_cnt
`endif
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

   fetch_state_t     r_state;
   fetch_state_t     w_state_next;
   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] w_pc_next;
   logic [WIDTH-1:0] r_req_pc;
   logic [WIDTH-1:0] w_req_pc_next;
   logic [CW-1:0]    w_count;
   logic [CW:0]      w_count_next;
   logic             w_space;
   logic             w_push;
   logic             w_pop;
   fetch_entry_t     w_push_entry;
   fetch_entry_t     w_head;

   assign w_push       = (r_state == WAIT) && i_imem_rvalid && !i_redirect;
   assign w_pop        = o_valid && i_id_ready;
   assign w_count_next = {1'b0, w_count} + (CW + 1)'(w_push) - (CW + 1)'(w_pop);
   // Nothing is outstanding whenever w_space is consulted, so the guard reduces to the FIFO count.
   assign w_space      = w_count_next < (CW + 1)'(FIFO_DEPTH);
   assign w_push_entry = '{pc: r_req_pc, instr: i_imem_rdata};

   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      w_state_next  = r_state;
      w_pc_next     = r_pc;
      w_req_pc_next = r_req_pc;
      case (r_state)
         IDLE:    if (w_space) w_state_next = REQ;
         REQ: begin
            if (i_imem_gnt) begin
               w_pc_next     = r_pc + WIDTH'(PC_INC);
               w_req_pc_next = r_pc;
               w_state_next  = WAIT;
            end
         end
         WAIT:    if (i_imem_rvalid) w_state_next = w_space ? REQ : IDLE;
         SQUASH:  if (i_imem_rvalid) w_state_next = REQ;
         default: w_state_next = IDLE;
      endcase

      // A redirect overrides everything; a granted-but-unanswered request must be squashed.
      if (i_redirect) begin
         w_pc_next = {i_redirect_pc[WIDTH-1:2], 2'b00};
         case (r_state)
            REQ:         w_state_next = i_imem_gnt ? SQUASH : REQ;
            WAIT,
            SQUASH:      w_state_next = i_imem_rvalid ? REQ : SQUASH;
            default:     w_state_next = REQ;
         endcase
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state  <= IDLE;
         r_pc     <= RESET_PC;
         r_req_pc <= '0;
      end else begin
         r_state  <= w_state_next;
         r_pc     <= w_pc_next;
         r_req_pc <= w_req_pc_next;
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clock   (i_clock),
      .i_reset_n (i_reset_n),
      .i_flush   (i_redirect),
      .i_push    (w_push),
      .i_data    (w_push_entry),
      .i_pop     (w_pop),
      .o_data    (w_head),
      .o_count   (w_count)
   );

   assign o_imem_req  = (r_state == REQ);
   assign o_imem_addr = r_pc;
   assign o_valid     = (w_count != '0);
   assign o_instr     = w_head.instr;
   assign o_instr_pc  = w_head.pc;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_flush_cnt;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (o_valid && !i_id_ready && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 32'd1;
         if (i_redirect && (r_flush_cnt != '1))             r_flush_cnt <= r_flush_cnt + 32'd1;
      end
   end

   assign o_stall_cnt = r_stall_cnt;
   assign o_flush_cnt = r_flush_cnt;
`endif

endmodule
